player_ctrl: RTL and testbench

PLAYER_CTRL -- requirements
Module: player_ctrl

---
 rtl/game_pkg.sv | 11 +
 rtl/player_ctrl.sv | 151 +++++++++++++++
 tb/tb_player_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game constants: movement steps, jump profile, playfield limit and
// the ObjectIDs reserved for the two bullet sprites.
package game_pkg;
  localparam int STEP_X         = 4;
  localparam int BULLET_STEP_X  = 6;
  localparam int V              = 20;
  localparam int MAX_J          = 80;
  localparam int LIMIT_X        = 600;
  localparam int OBJECT_BULLET1 = 7;
  localparam int OBJECT_BULLET2 = 8;
endpackage

// File: rtl/player_ctrl.sv
// Per-player controller: walk/jump/squat/shield FSM plus a single bullet.
// Everything advances once per enabled frame tick; a bullet hit retires the
// bullet on the very next clock edge.
//
//   state      | meaning
//   -----------+----------------------------------------------
//   IDLE       | standing, may walk, may start jump/squat/shield
//   JUMP_UP    | rising by V per frame until MAX_J
//   JUMP_DOWN  | falling by V per frame until 0
//   SQUAT      | crouched while i_squat held, no walking
//   SHIELD     | shielded while i_shield held, no walking
module player_ctrl
  import game_pkg::*;
#(
  parameter int PLAYER_ID = 1,
  parameter int INIT_X    = -500,
  parameter int DIR       = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_frame_tick,
  input  logic               i_enable,
  input  logic               i_left,
  input  logic               i_right,
  input  logic               i_jump,
  input  logic               i_squat,
  input  logic               i_shield,
  input  logic               i_fire,
  input  logic               i_bullet_hit,
  output logic signed [10:0] o_x,
  output logic        [6:0]  o_y,
  output logic        [3:0]  o_obj_id,
  output logic               o_bullet_valid,
  output logic signed [10:0] o_bullet_x,
  output logic               o_bullet_low,
  output logic        [3:0]  o_bullet_id
);

  localparam logic [3:0] OBJ_BASE   = 4'(3 * (PLAYER_ID - 1));
  localparam logic [3:0] OBJ_STAND  = OBJ_BASE + 4'd1;
  localparam logic [3:0] OBJ_SHIELD = OBJ_BASE + 4'd2;
  localparam logic [3:0] OBJ_SQUAT  = OBJ_BASE + 4'd3;
  localparam logic [3:0] BULLET_ID  = (PLAYER_ID == 2) ? 4'(OBJECT_BULLET2)
                                                       : 4'(OBJECT_BULLET1);
  localparam logic signed [10:0] X_RESET = 11'(INIT_X);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_JUMP_UP,
    ST_JUMP_DOWN,
    ST_SQUAT,
    ST_SHIELD
  } state_t;

  state_t             state, state_nxt;
  logic               upd;
  int                 y_up, y_dn;
  int                 x_mv, bx_mv;
  logic signed [10:0] x_nxt, bx_nxt;
  logic        [6:0]  y_nxt;
  logic        [3:0]  obj_nxt;
  logic               bv_nxt, bl_nxt;

  assign upd         = i_frame_tick & i_enable;
  assign y_up        = int'(o_y) + V;
  assign y_dn        = int'(o_y) - V;
  assign o_bullet_id = BULLET_ID;

  // State and all outputs register here; hit retires the bullet on any edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state          <= ST_IDLE;
      o_x            <= X_RESET;
      o_y            <= '0;
      o_obj_id       <= OBJ_STAND;
      o_bullet_valid <= 1'b0;
      o_bullet_x     <= '0;
      o_bullet_low   <= 1'b0;
    end else begin
      if (upd) begin
        state    <= state_nxt;
        o_x      <= x_nxt;
        o_y      <= y_nxt;
        o_obj_id <= obj_nxt;
      end
      if (i_bullet_hit) begin
        o_bullet_valid <= 1'b0;
      end else if (upd) begin
        o_bullet_valid <= bv_nxt;
        o_bullet_x     <= bx_nxt;
        o_bullet_low   <= bl_nxt;
      end
    end
  end

  // Next-state: jump beats squat beats shield; jump runs to completion.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (i_jump)        state_nxt = ST_JUMP_UP;
        else if (i_squat)  state_nxt = ST_SQUAT;
        else if (i_shield) state_nxt = ST_SHIELD;
      end
      ST_JUMP_UP:   if (y_up >= MAX_J) state_nxt = ST_JUMP_DOWN;
      ST_JUMP_DOWN: if (y_dn <= 0)     state_nxt = ST_IDLE;
      ST_SQUAT:     if (!i_squat)      state_nxt = ST_IDLE;
      ST_SHIELD:    if (!i_shield)     state_nxt = ST_IDLE;
      default:                         state_nxt = ST_IDLE;
    endcase
  end

  // Output next-values: clamped walk, jump height, sprite id, bullet motion.
  always_comb begin
    x_mv = int'(o_x);
    if ((state == ST_IDLE || state == ST_JUMP_UP || state == ST_JUMP_DOWN) &&
        (i_left != i_right)) begin
      x_mv = i_left ? (x_mv - STEP_X) : (x_mv + STEP_X);
    end
    if (x_mv > LIMIT_X)       x_mv = LIMIT_X;
    else if (x_mv < -LIMIT_X) x_mv = -LIMIT_X;
    x_nxt = 11'(x_mv);

    case (state)
      ST_JUMP_UP:   y_nxt = (y_up >= MAX_J) ? 7'(MAX_J) : 7'(y_up);
      ST_JUMP_DOWN: y_nxt = (y_dn <= 0) ? 7'd0 : 7'(y_dn);
      default:      y_nxt = o_y;
    endcase

    case (state_nxt)
      ST_SQUAT:  obj_nxt = OBJ_SQUAT;
      ST_SHIELD: obj_nxt = OBJ_SHIELD;
      default:   obj_nxt = OBJ_STAND;
    endcase

    // A bullet that would leave the field disappears where it last was.
    bx_mv  = int'(o_bullet_x) + DIR * BULLET_STEP_X;
    bv_nxt = o_bullet_valid;
    bx_nxt = o_bullet_x;
    bl_nxt = o_bullet_low;
    if (o_bullet_valid) begin
      if (bx_mv > LIMIT_X || bx_mv < -LIMIT_X) bv_nxt = 1'b0;
      else                                     bx_nxt = 11'(bx_mv);
    end else if (i_fire && (state == ST_IDLE || state == ST_SQUAT)) begin
      bv_nxt = 1'b1;
      bx_nxt = o_x;
      bl_nxt = (state == ST_SQUAT);
    end
  end

endmodule

// File: tb/tb_player_ctrl.sv
// Directed bench for player_ctrl. Four instances share the frame tick and
// player controls; each has its own enable so only the one under test moves.
module tb_player_ctrl;

  logic clk = 1'b0;
  logic rst_n, tick, left, right, jump, squat, shield, fire, hit;
  logic en_a, en_b, en_c, en_d;

  logic signed [10:0] x_a, x_b, x_c, x_d, bx_a, bx_b, bx_c, bx_d;
  logic        [6:0]  y_a, y_b, y_c, y_d;
  logic        [3:0]  obj_a, obj_b, obj_c, obj_d, bid_a, bid_b, bid_c, bid_d;
  logic               bv_a, bv_b, bv_c, bv_d, bl_a, bl_b, bl_c, bl_d;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  player_ctrl u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_tick(tick), .i_enable(en_a),
    .i_left(left), .i_right(right), .i_jump(jump), .i_squat(squat),
    .i_shield(shield), .i_fire(fire), .i_bullet_hit(hit),
    .o_x(x_a), .o_y(y_a), .o_obj_id(obj_a), .o_bullet_valid(bv_a),
    .o_bullet_x(bx_a), .o_bullet_low(bl_a), .o_bullet_id(bid_a)
  );

  player_ctrl #(.PLAYER_ID(2), .INIT_X(598), .DIR(1)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_tick(tick), .i_enable(en_b),
    .i_left(left), .i_right(right), .i_jump(jump), .i_squat(squat),
    .i_shield(shield), .i_fire(fire), .i_bullet_hit(hit),
    .o_x(x_b), .o_y(y_b), .o_obj_id(obj_b), .o_bullet_valid(bv_b),
    .o_bullet_x(bx_b), .o_bullet_low(bl_b), .o_bullet_id(bid_b)
  );

  player_ctrl #(.PLAYER_ID(1), .INIT_X(-598), .DIR(-1)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_tick(tick), .i_enable(en_c),
    .i_left(left), .i_right(right), .i_jump(jump), .i_squat(squat),
    .i_shield(shield), .i_fire(fire), .i_bullet_hit(hit),
    .o_x(x_c), .o_y(y_c), .o_obj_id(obj_c), .o_bullet_valid(bv_c),
    .o_bullet_x(bx_c), .o_bullet_low(bl_c), .o_bullet_id(bid_c)
  );

  player_ctrl #(.PLAYER_ID(1), .INIT_X(590), .DIR(1)) u_d (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_tick(tick), .i_enable(en_d),
    .i_left(left), .i_right(right), .i_jump(jump), .i_squat(squat),
    .i_shield(shield), .i_fire(fire), .i_bullet_hit(hit),
    .o_x(x_d), .o_y(y_d), .o_obj_id(obj_d), .o_bullet_valid(bv_d),
    .o_bullet_x(bx_d), .o_bullet_low(bl_d), .o_bullet_id(bid_d)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; raises tick across exactly one rising edge.
  task automatic frame();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  int jump_y [8] = '{20, 40, 60, 80, 60, 40, 20, 0};

  initial begin
    rst_n = 1'b0; tick = 1'b0; left = 1'b0; right = 1'b0; jump = 1'b0;
    squat = 1'b0; shield = 1'b0; fire = 1'b0; hit = 1'b0;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0; en_d = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset values
    chk("rst_x_a", int'(x_a), -500);
    chk("rst_y_a", int'(y_a), 0);
    chk("rst_obj_a", int'(obj_a), 1);
    chk("rst_bv_a", int'(bv_a), 0);
    chk("rst_bx_a", int'(bx_a), 0);
    chk("rst_bl_a", int'(bl_a), 0);
    chk("rst_obj_b", int'(obj_b), 4);
    chk("bid_a", int'(bid_a), 7);
    chk("bid_b", int'(bid_b), 8);

    // Walk right three frames, then frames with enable low
    en_a = 1'b1; right = 1'b1;
    frame(); chk("walk1_x", int'(x_a), -496);
    frame(); chk("walk2_x", int'(x_a), -492);
    frame(); chk("walk3_x", int'(x_a), -488);
    repeat (3) @(negedge clk);
    chk("no_tick_x", int'(x_a), -488);
    en_a = 1'b0;
    frame(); frame();
    chk("disabled_x", int'(x_a), -488);
    right = 1'b0;

    // Right clamp, then both pressed
    en_b = 1'b1; right = 1'b1;
    frame(); chk("clamp_hi_x", int'(x_b), 600);
    frame(); chk("clamp_hi_hold", int'(x_b), 600);
    left = 1'b1;
    frame(); chk("both_x", int'(x_b), 600);
    right = 1'b0; en_b = 1'b0;

    // Left clamp
    en_c = 1'b1;
    frame(); chk("clamp_lo_x", int'(x_c), -600);
    left = 1'b0; en_c = 1'b0;

    // Jump profile with squat held during the jump
    en_a = 1'b1; jump = 1'b1;
    frame();
    chk("jump_start_y", int'(y_a), 0);
    jump = 1'b0; squat = 1'b1;
    for (int i = 0; i < 8; i++) begin
      frame();
      chk($sformatf("jump_y%0d", i), int'(y_a), jump_y[i]);
      chk($sformatf("jump_obj%0d", i), int'(obj_a), 1);
    end
    squat = 1'b0; shield = 1'b1;
    frame(); chk("post_jump_shield_obj", int'(obj_a), 2);
    shield = 1'b0;
    frame(); chk("shield_release_obj", int'(obj_a), 1);
    chk("jump_x_hold", int'(x_a), -488);
    en_a = 1'b0;

    // Player 2: squat, fire low bullet, second fire ignored in flight
    en_b = 1'b1; left = 1'b1;
    frame(); frame(); frame();
    chk("p2_walk_x", int'(x_b), 588);
    left = 1'b0; squat = 1'b1;
    frame(); chk("p2_squat_obj", int'(obj_b), 6);
    fire = 1'b1;
    frame();
    chk("p2_fire_bv", int'(bv_b), 1);
    chk("p2_fire_bl", int'(bl_b), 1);
    chk("p2_fire_bx", int'(bx_b), 588);
    chk("p2_bid", int'(bid_b), 8);
    frame(); chk("p2_refire_bx", int'(bx_b), 594);
    frame(); chk("p2_fly_bx", int'(bx_b), 600);
    chk("p2_fly_bv", int'(bv_b), 1);
    frame(); chk("p2_exit_bv", int'(bv_b), 0);
    chk("p2_exit_bx", int'(bx_b), 600);
    fire = 1'b0; squat = 1'b0;
    frame(); chk("p2_unsquat_obj", int'(obj_b), 4);
    en_b = 1'b0;

    // Bullet from 590 toward the right edge, then a hit mid-flight
    en_d = 1'b1; fire = 1'b1;
    frame();
    chk("d_fire_bx", int'(bx_d), 590);
    chk("d_fire_bl", int'(bl_d), 0);
    fire = 1'b0;
    frame(); chk("d_fly_bx", int'(bx_d), 596);
    chk("d_fly_bv", int'(bv_d), 1);
    frame(); chk("d_exit_bv", int'(bv_d), 0);
    chk("d_exit_bx", int'(bx_d), 596);
    fire = 1'b1;
    frame(); chk("d_refire_bv", int'(bv_d), 1);
    fire = 1'b0;
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    chk("d_hit_bv", int'(bv_d), 0);
    en_d = 1'b0;

    // Reset mid-jump with a bullet in flight
    en_a = 1'b1; fire = 1'b1;
    frame(); chk("a_fire_bx", int'(bx_a), -488);
    fire = 1'b0; jump = 1'b1;
    frame(); chk("a_fly_bx", int'(bx_a), -482);
    jump = 1'b0;
    frame(); frame();
    chk("a_mid_y", int'(y_a), 40);
    chk("a_mid_bv", int'(bv_a), 1);
    rst_n = 1'b0; tick = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; tick = 1'b0;
    chk("mid_rst_y", int'(y_a), 0);
    chk("mid_rst_bv", int'(bv_a), 0);
    chk("mid_rst_x", int'(x_a), -500);
    chk("mid_rst_obj", int'(obj_a), 1);
    chk("mid_rst_bx", int'(bx_a), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
